bsg_wormhole_concentrator_out: RTL and testbench
================================================

Name: bsg_wormhole_concentrator_out

Overview:
- Adapter from one concentrated wormhole link to num_out_p unconcentrated wormhole links; the demultiplexing counterpart of the N-to-1 concentrator.
- Each packet's header carries a cid field that selects one output link. The whole packet (header plus len_field payload flits) is forwarded to that link without interleaving.
- Sits between a shared concentrated link and per-tile or per-client wormhole endpoints.
- 1-cycle latency from input to output; zero bubble between packets.

Parameters:
- flit_width_p, none (required), width of every flit.
- len_width_p, none (required), width of header len field.
- cord_width_p, none (required), width of header cord field.
- cid_width_p, none (required), width of header cid field; must be >= max(1, clog2(num_out_p)).
- num_out_p, 1, number of unconcentrated output links.
- debug_lp, 0, nonzero enables simulation assertions and routing messages.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- concentrated_link_v_i  in  1  concentrated flit valid
- concentrated_link_data_i  in  flit_width_p  concentrated flit
- concentrated_link_ready_and_rev_o  out  1  ready to accept concentrated flit
- links_v_o  out  num_out_p  per-output flit valid
- links_data_o  out  num_out_p*flit_width_p  per-output flit (all outputs carry the same buffered flit)
- links_ready_and_rev_i  in  num_out_p  per-output ready

Behaviour:
- Header layout, LSB first: cord [cord_width_p-1:0], then len [len_width_p-1:0], then cid [cid_width_p-1:0]. The header must fit in flit_width_p.
- Input buffer: two-element FIFO on the concentrated link.
  - ready_o = FIFO not full.
  - A flit is enqueued when v_i & ready_o.
  - Full with a simultaneous dequeue: ready_o stays 0 that cycle, then becomes 1 (standard two-fifo).
- Control FSM (registered):
  - HDR state (reset state). FIFO head is a header.
    - dest = one-hot(cid).
    - When the head is dequeued: if len == 0, stay in HDR; otherwise latch dest_r = dest, load cnt_r = len, go to BODY.
  - BODY state. Head routes to dest_r.
    - Each dequeue decrements cnt_r.
    - The dequeue with cnt_r == 1 returns the FSM to HDR.
  - cnt_r is len_width_p wide. Max len = 2^len_width_p - 1 payload flits; no wrap.
- Output routing:
  - sel = dest (in HDR) or dest_r (in BODY).
  - links_v_o = sel & {num_out_p{fifo_v}}.
  - links_data_o[k] = fifo head for every k.
  - Dequeue (yumi) = fifo_v & |(sel & links_ready_and_rev_i).
  - A non-selected output's ready has no effect; its valid is 0.
- Backpressure: a stalled output holds its packet mid-flight. Later packets for other outputs wait behind it (no reordering, head-of-line blocking is accepted).
- Out-of-range cid (cid >= num_out_p): routed to output 0. debug_lp asserts an error.
- Reset values: links_v_o = 0, ready_o = 0 during reset and 1 on the first cycle after release, FSM = HDR, cnt_r = 0, dest_r = 0.
- Reset asserted mid-packet: FIFO and FSM clear. The next accepted flit is treated as a header; the remaining old payload must not be sent.
- No combinational path from links_ready_and_rev_i to concentrated_link_ready_and_rev_o.

Optional Feature:
- Macro: BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN.
- Defined: an out-of-range cid header starts a DROP state.
  - All flits of that packet (header plus len) are dequeued, with all links_v_o = 0.
  - The sticky output port bad_cid_o (1 bit, reset 0) is set.
- Undefined: the bad_cid_o port does not exist, and out-of-range packets route to output 0 as above.

Test Plan:
- num_out_p=4, len_width_p=4. Header cid=2 len=3 then 3 payload flits, all ready high -> links_v_o=4'b0100 on 4 consecutive cycles starting 1 cycle after the header is accepted; data is bit-exact.
- Back-to-back packets cid=1 len=0, then cid=3 len=2 -> valid on output 1 for 1 cycle, immediately followed by output 3 for 3 cycles, no bubble.
- Packet cid=0 len=5 with links_ready_and_rev_i[0] toggling 1010... -> every flit delivered once, in order. FIFO fills and ready_o drops after 2 buffered flits. ready_i of outputs 1-3 is ignored.
- reset_i asserted after header plus 2 of 5 payload flits, then a fresh header cid=1 len=1 -> after reset, output 1 gets exactly 2 flits; outputs 0, 2 and 3 stay idle.
- num_out_p=3, cid=3 len=2: without the macro -> 3 flits on output 0. With BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN -> no valids, 3 flits consumed, bad_cid_o=1 and held.
- Random cid/len traffic with random per-output ready for 10k flits -> per-output scoreboard matches, with no interleaving within any packet.

Source files
------------

// File: rtl/bsg_wormhole_concentrator_out.sv
// 1-to-N wormhole demultiplexer: splits one concentrated link into num_out_p links by header cid.
// Optional macro BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN drops out-of-range cid packets and flags bad_cid_o.
module bsg_wormhole_concentrator_out #(
   parameter int flit_width_p = 16,
   parameter int len_width_p  = 4,
   parameter int cord_width_p = 4,
   parameter int cid_width_p  = 2,
   parameter int num_out_p    = 1,
   parameter int debug_lp     = 0
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              concentrated_link_v_i,
   input  logic [flit_width_p-1:0]           concentrated_link_data_i,
   output logic                              concentrated_link_ready_and_rev_o,
   output logic [num_out_p-1:0]              links_v_o,
   output logic [num_out_p*flit_width_p-1:0] links_data_o,
   input  logic [num_out_p-1:0]              links_ready_and_rev_i
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
   ,
   output logic                              bad_cid_o
`endif
);

`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
   typedef enum logic [1:0] {HDR_S, BODY_S, DROP_S} state_e;
`else
   typedef enum logic [1:0] {HDR_S, BODY_S} state_e;
`endif

   logic [flit_width_p-1:0] fifo_mem [2];
   logic                    wr_ptr, rd_ptr;
   logic [1:0]              fifo_cnt;
   logic                    fifo_v, fifo_full, enq, yumi;
   logic [flit_width_p-1:0] head;

   state_e                  state_r;
   logic [len_width_p-1:0]  cnt_r;
   logic [num_out_p-1:0]    dest_r, dest, sel;
   logic [len_width_p-1:0]  hdr_len;
   logic [cid_width_p-1:0]  hdr_cid;
   logic                    cid_in_range, drop_head;

   // Two-entry input buffer; ready depends only on occupancy, never on the output readies.
   assign fifo_v    = (fifo_cnt != 2'd0);
   assign fifo_full = (fifo_cnt == 2'd2);
   assign concentrated_link_ready_and_rev_o = ~fifo_full & ~reset_i;
   assign enq  = concentrated_link_v_i & concentrated_link_ready_and_rev_o;
   assign head = fifo_mem[rd_ptr];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (enq)  wr_ptr <= ~wr_ptr;
         if (yumi) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + 2'(enq) - 2'(yumi);
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) fifo_mem[wr_ptr] <= concentrated_link_data_i;
   end

   assign hdr_len      = head[cord_width_p +: len_width_p];
   assign hdr_cid      = head[cord_width_p+len_width_p +: cid_width_p];
   assign cid_in_range = (32'(hdr_cid) < 32'(num_out_p));

   // Out-of-range cids fall back to output 0 unless the drop feature intercepts them.
   always_comb begin
      dest = '0;
      for (int k = 0; k < num_out_p; k++) begin
         if (hdr_cid == cid_width_p'(k)) dest[k] = 1'b1;
      end
      if (!cid_in_range) dest = num_out_p'(1);
   end

   always_comb begin
      sel       = '0;
      drop_head = 1'b0;
      case (state_r)
         HDR_S: begin
            sel = dest;
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
            if (!cid_in_range) begin
               sel       = '0;
               drop_head = 1'b1;
            end
`endif
         end
         BODY_S: sel = dest_r;
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
         DROP_S: drop_head = 1'b1;
`endif
         default: sel = '0;
      endcase
   end

   assign yumi         = fifo_v & (drop_head | (|(sel & links_ready_and_rev_i)));
   assign links_v_o    = sel & {num_out_p{fifo_v}};
   assign links_data_o = {num_out_p{head}};

   // Packet tracker: a zero-length header never leaves HDR; otherwise count payload flits down.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= HDR_S;
         cnt_r   <= '0;
         dest_r  <= '0;
      end else if (yumi) begin
         case (state_r)
            HDR_S: begin
               if (hdr_len != '0) begin
                  cnt_r  <= hdr_len;
                  dest_r <= dest;
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
                  state_r <= cid_in_range ? BODY_S : DROP_S;
`else
                  state_r <= BODY_S;
`endif
               end
            end
            default: begin
               cnt_r <= cnt_r - len_width_p'(1);
               if (cnt_r == len_width_p'(1)) state_r <= HDR_S;
            end
         endcase
      end
   end

`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                                        bad_cid_o <= 1'b0;
      else if (yumi && state_r == HDR_S && !cid_in_range) bad_cid_o <= 1'b1;
   end
`endif

   // Simulation-only sanity check that every consumed header names a real output.
   if (debug_lp != 0) begin : g_debug
      always_ff @(posedge clk_i) begin
         if (!reset_i && yumi && state_r == HDR_S) assert (cid_in_range);
      end
   end

endmodule

// File: tb/tb_bsg_wormhole_concentrator_out.sv
// Scoreboard bench for bsg_wormhole_concentrator_out (4 outputs, 3-bit cid so out-of-range cids exist).
module tb_bsg_wormhole_concentrator_out;
   localparam int FW = 16;
   localparam int NO = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            v_in;
   logic [FW-1:0]   data_in;
   logic            ready_out;
   logic [NO-1:0]   links_v;
   logic [NO*FW-1:0] links_data;
   logic [NO-1:0]   links_ready = '1;
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
   logic            bad_cid;
`endif

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ready_mode = 0;
   int gap_en = 0;
   bit stall_seen = 0;
   int hdr_cyc = 0;
   int total_flits = 0;

   logic [FW-1:0] exp_q [NO][$];
   int            xfer_log [$];

   bsg_wormhole_concentrator_out #(
      .flit_width_p(FW), .len_width_p(4), .cord_width_p(4),
      .cid_width_p(3), .num_out_p(NO), .debug_lp(0)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .concentrated_link_v_i(v_in),
      .concentrated_link_data_i(data_in),
      .concentrated_link_ready_and_rev_o(ready_out),
      .links_v_o(links_v),
      .links_data_o(links_data),
      .links_ready_and_rev_i(links_ready)
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
      ,
      .bad_cid_o(bad_cid)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Output readiness: 0 all high, 1 random (75%), 2 output 0 toggles and others random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         1: for (int k = 0; k < NO; k++) links_ready[k] = ($urandom_range(0, 3) != 0);
         2: begin
            links_ready[0] = ~links_ready[0];
            for (int k = 1; k < NO; k++) links_ready[k] = $urandom_range(0, 1) != 0;
         end
         default: links_ready = '1;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every handshaken output flit must be the next one the model expects on that port.
   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NO; k++) begin
            if (links_v[k] && links_ready[k]) begin
               xfer_log.push_back(cyc * 8 + k);
               if (exp_q[k].size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL unexpected_flit: port %0d got %0h, expected none", k, links_data[k*FW +: FW]);
               end else begin
                  checkOutput($sformatf("data_port%0d", k), 32'(links_data[k*FW +: FW]), 32'(exp_q[k].pop_front()));
               end
            end
         end
      end
   end

   task automatic send_flit(input logic [FW-1:0] f, output int acc_cyc);
      bit accepted = 0;
      acc_cyc = -1;
      if (gap_en != 0 && $urandom_range(0, 7) == 0) begin
         v_in = 1'b0;
         @(posedge clk); #1;
      end
      v_in = 1'b1;
      data_in = f;
      for (int t = 0; t < 300 && !accepted; t++) begin
         @(negedge clk);
         if (ready_out) begin
            accepted = 1;
            acc_cyc = cyc;
         end else stall_seen = 1;
         @(posedge clk); #1;
      end
      v_in = 1'b0;
      if (!accepted) begin
         tests++;
         fails++;
         $display("[TB] FAIL send_timeout: got no ready, expected accept of %0h", f);
      end
   endtask

   // Model: cid picks the output; out-of-range goes to output 0, or nowhere when dropping.
   task automatic applyStimulus(input int cid, input int len, input int n_send);
      logic [FW-1:0] pkt [$];
      logic [FW-1:0] hdr;
      int port, ac;
      hdr = FW'($urandom);
      hdr[3:0]  = 4'($urandom);
      hdr[7:4]  = len[3:0];
      hdr[10:8] = cid[2:0];
      pkt.push_back(hdr);
      for (int i = 0; i < len; i++) pkt.push_back(FW'($urandom));
      port = (cid < NO) ? cid : 0;
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
      if (cid >= NO) port = -1;
`endif
      if (port >= 0) foreach (pkt[i]) exp_q[port].push_back(pkt[i]);
      for (int i = 0; i < pkt.size() && i < n_send; i++) begin
         send_flit(pkt[i], ac);
         if (i == 0) hdr_cyc = ac;
         total_flits++;
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkLog(input string name, input int idx, input int exp);
      if (idx < xfer_log.size()) checkOutput(name, 32'(xfer_log[idx]), 32'(exp));
      else checkOutput(name, 32'hDEAD, 32'(exp));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      foreach (exp_q[k]) exp_q[k].delete();
      @(negedge clk);
      checkOutput("reset_ready", 32'(ready_out), 32'd0);
      checkOutput("reset_links_v", 32'(links_v), 32'd0);
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
      checkOutput("reset_bad_cid", 32'(bad_cid), 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      xfer_log.delete();
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(ready_out), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      v_in = 1'b0;
      data_in = '0;
      wait_cycles(2);
      do_reset();

      // Single packet, all ready: four consecutive cycles on output 2.
      xfer_log.delete();
      applyStimulus(2, 3, 99);
      wait_cycles(4);
      for (int i = 0; i < 4; i++) checkLog("pkt_cid2_timing", i, (hdr_cyc + 1 + i) * 8 + 2);
      checkOutput("pkt_cid2_count", 32'(xfer_log.size()), 32'd4);

      // Back-to-back packets with no bubble between them.
      xfer_log.delete();
      begin
         int c0;
         applyStimulus(1, 0, 99);
         c0 = hdr_cyc;
         applyStimulus(3, 2, 99);
         wait_cycles(4);
         checkLog("b2b_first", 0, (c0 + 1) * 8 + 1);
         for (int i = 0; i < 3; i++) checkLog("b2b_second", i + 1, (c0 + 2 + i) * 8 + 3);
      end

      // Toggling ready on output 0 fills the buffer and stalls the input.
      ready_mode = 2;
      stall_seen = 0;
      applyStimulus(0, 5, 99);
      wait_cycles(12);
      checkOutput("toggle_stall_seen", 32'(stall_seen), 32'd1);
      checkOutput("toggle_drained", 32'(exp_q[0].size()), 32'd0);
      ready_mode = 0;
      wait_cycles(2);

      // Reset mid-packet, then a fresh packet must be treated as a header.
      applyStimulus(0, 5, 3);
      do_reset();
      applyStimulus(1, 1, 99);
      wait_cycles(5);
      checkOutput("post_reset_count", 32'(xfer_log.size()), 32'd2);
      foreach (xfer_log[i]) checkOutput("post_reset_port", 32'(xfer_log[i] % 8), 32'd1);

      // Out-of-range cid.
      xfer_log.delete();
      applyStimulus(5, 2, 99);
      wait_cycles(5);
`ifdef BSG_WORMHOLE_CONCENTRATOR_OUT_DROP_EN
      checkOutput("drop_no_valid", 32'(xfer_log.size()), 32'd0);
      checkOutput("drop_bad_cid", 32'(bad_cid), 32'd1);
      wait_cycles(10);
      checkOutput("drop_bad_cid_held", 32'(bad_cid), 32'd1);
      checkOutput("drop_consumed", 32'(ready_out), 32'd1);
`else
      checkOutput("oor_count", 32'(xfer_log.size()), 32'd3);
      foreach (xfer_log[i]) checkOutput("oor_port", 32'(xfer_log[i] % 8), 32'd0);
`endif

      // Random traffic.
      ready_mode = 1;
      gap_en = 1;
      total_flits = 0;
      while (total_flits < 10000) applyStimulus($urandom_range(0, 7), $urandom_range(0, 15), 99);
      gap_en = 0;
      ready_mode = 0;
      for (int t = 0; t < 2000; t++) begin
         if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
         wait_cycles(1);
      end
      wait_cycles(3);
      for (int k = 0; k < NO; k++) checkOutput($sformatf("final_queue%0d", k), 32'(exp_q[k].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
